// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and byte helpers for the data cache.
package cache_pkg;

  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int TAG_W       = 3;
  localparam int INDEX_W     = 3;
  localparam int OFFSET_W    = 2;
  localparam int BLOCK_W     = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } cache_state_e;

  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFFSET_W-1:0] off);
    return blk[off*8 +: 8];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: combinational read of the indexed line,
// posedge byte-write and whole-line refill ports.
module dcache_array
  import cache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  index,
  output logic                line_valid,
  output logic                line_dirty,
  output logic [TAG_W-1:0]    line_tag,
  output logic [BLOCK_W-1:0]  line_data,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] byte_offset,
  input  logic [7:0]          byte_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data
);

  logic [NUM_BLOCKS-1:0] valid_vec;
  logic [NUM_BLOCKS-1:0] dirty_vec;
  logic [TAG_W-1:0]      tag_vec  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_vec [NUM_BLOCKS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_line
      logic               valid_reg;
      logic               dirty_reg;
      logic [TAG_W-1:0]   tag_reg;
      logic [BLOCK_W-1:0] data_reg;
      logic               sel;

      assign sel = (index == INDEX_W'(gi));

      // Refill wins over a byte write; the FSM never issues both at once.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          valid_reg <= 1'b0;
          dirty_reg <= 1'b0;
        end else if (fill_we && sel) begin
          valid_reg <= 1'b1;
          dirty_reg <= 1'b0;
          tag_reg   <= fill_tag;
          data_reg  <= fill_data;
        end else if (byte_we && sel) begin
          dirty_reg <= 1'b1;
          data_reg[byte_offset*8 +: 8] <= byte_data;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign dirty_vec[gi] = dirty_reg;
      assign tag_vec[gi]   = tag_reg;
      assign data_vec[gi]  = data_reg;
    end
  endgenerate

  assign line_valid = valid_vec[index];
  assign line_dirty = dirty_vec[index];
  assign line_tag   = tag_vec[index];
  assign line_data  = data_vec[index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate byte cache in front of a
// 32-bit-block data memory; stalls the CPU via BUSYWAIT during refills.
module dcache
  import cache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  cache_state_e state_reg;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                hit;
  logic                request;

  assign addr_tag    = ADDRESS[7:5];
  assign addr_index  = ADDRESS[4:2];
  assign addr_offset = ADDRESS[1:0];

  assign hit     = line_valid && (line_tag == addr_tag);
  assign request = READ || WRITE;

  dcache_array u_array (
    .CLK         (CLK),
    .RESET       (RESET),
    .index       (addr_index),
    .line_valid  (line_valid),
    .line_dirty  (line_dirty),
    .line_tag    (line_tag),
    .line_data   (line_data),
    .byte_we     (state_reg == IDLE && WRITE && hit),
    .byte_offset (addr_offset),
    .byte_data   (WRITEDATA),
    .fill_we     (state_reg == UPDATE),
    .fill_tag    (addr_tag),
    .fill_data   (MEM_READDATA)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:      if (request && !hit)
                     state_reg <= (line_valid && line_dirty) ? WRITEBACK : FETCH;
        WRITEBACK: if (!MEM_BUSYWAIT) state_reg <= FETCH;
        FETCH:     if (!MEM_BUSYWAIT) state_reg <= UPDATE;
        UPDATE:    state_reg <= IDLE;
        default:   state_reg <= IDLE;
      endcase
    end
  end

  // The held request completes in IDLE only once it hits, including after a refill.
  assign BUSYWAIT      = request && !(state_reg == IDLE && hit);
  assign MEM_READ      = (state_reg == FETCH);
  assign MEM_WRITE     = (state_reg == WRITEBACK);
  assign MEM_ADDRESS   = (state_reg == WRITEBACK) ? {line_tag, addr_index} : ADDRESS[7:2];
  assign MEM_WRITEDATA = line_data;
  assign READDATA      = hit ? block_byte(line_data, addr_offset) : 8'h00;

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache with a 5-cycle-latency block memory model.
module tb_dcache;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: a transaction holds MEM_BUSYWAIT for 4 cycles, drops it on the 5th.
  logic [31:0] mem [0:63];
  logic [2:0]  mem_cnt = 3'd0;
  logic        mem_ready = 1'b0;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < 3'd4);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem[6'h00] <= 32'h4433_2211;
      mem[6'h08] <= 32'h8877_6655;
      mem[6'h11] <= 32'hDDCC_BBAA;
      mem[6'h19] <= 32'h0F0E_0D0C;
      mem_ready  <= 1'b1;
    end else if (MEM_WRITE && !MEM_BUSYWAIT && !RESET) begin
      mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end
    if (RESET || !MEM_BUSYWAIT) mem_cnt <= 3'd0;
    else                        mem_cnt <= mem_cnt + 3'd1;
  end

  // Traffic monitor: records completed memory transactions.
  int          n_fetch = 0;
  int          n_wb = 0;
  int          n_both = 0;
  logic [5:0]  last_fetch_addr = 6'h3F;
  logic [5:0]  last_wb_addr = 6'h3F;
  logic [31:0] last_wb_data = 32'h0;

  always @(posedge CLK) begin
    if (!RESET) begin
      if (MEM_READ && MEM_WRITE) n_both <= n_both + 1;
      if (MEM_READ && !MEM_BUSYWAIT) begin
        n_fetch         <= n_fetch + 1;
        last_fetch_addr <= MEM_ADDRESS;
      end
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
        n_wb         <= n_wb + 1;
        last_wb_addr <= MEM_ADDRESS;
        last_wb_data <= MEM_WRITEDATA;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a request at a negedge and wait (bounded) until BUSYWAIT drops.
  task automatic req_op(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, output int stalls, output logic [7:0] rdata);
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    #1;
    stalls = 0;
    while (BUSYWAIT && stalls < 200) begin
      stalls++;
      @(negedge CLK);
      #1;
    end
    rdata = READDATA;
    $display("op rd=%0b wr=%0b addr=%02h wdata=%02h -> readdata=%02h stalls=%0d",
             rd, wr, addr, wd, rdata, stalls);
  endtask

  int         st;
  logic [7:0] rd;

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    check("rst_readdata", 32'(READDATA), 32'h00);

    // Cold read miss at 0x00
    req_op(1'b1, 1'b0, 8'h00, 8'h00, st, rd);
    check("miss0_stalls", 32'(st), 32'd7);
    check("miss0_data", 32'(rd), 32'h11);
    check("miss0_nfetch", 32'(n_fetch), 32'd1);
    check("miss0_faddr", 32'(last_fetch_addr), 32'h00);
    check("miss0_nwb", 32'(n_wb), 32'd0);

    // Hits in the refilled line
    req_op(1'b1, 1'b0, 8'h03, 8'h00, st, rd);
    check("hit3_stalls", 32'(st), 32'd0);
    check("hit3_data", 32'(rd), 32'h44);
    req_op(1'b1, 1'b0, 8'h02, 8'h00, st, rd);
    check("hit2_stalls", 32'(st), 32'd0);
    check("hit2_data", 32'(rd), 32'h33);
    check("hits_nfetch", 32'(n_fetch), 32'd1);

    // Write hit then read back
    req_op(1'b0, 1'b1, 8'h01, 8'hAB, st, rd);
    check("whit_stalls", 32'(st), 32'd0);
    req_op(1'b1, 1'b0, 8'h01, 8'h00, st, rd);
    check("whit_rd_stalls", 32'(st), 32'd0);
    check("whit_rd_data", 32'(rd), 32'hAB);
    check("whit_nwb", 32'(n_wb), 32'd0);

    // Conflict miss with dirty victim
    req_op(1'b1, 1'b0, 8'h21, 8'h00, st, rd);
    check("evict0_stalls", 32'(st), 32'd12);
    check("evict0_nwb", 32'(n_wb), 32'd1);
    check("evict0_wbaddr", 32'(last_wb_addr), 32'h00);
    check("evict0_wbdata", last_wb_data, 32'h4433_AB11);
    check("evict0_faddr", 32'(last_fetch_addr), 32'h08);
    check("evict0_data", 32'(rd), 32'h66);

    // Write miss on an invalid line ends dirty
    req_op(1'b0, 1'b1, 8'h45, 8'h5A, st, rd);
    check("wmiss_stalls", 32'(st), 32'd7);
    check("wmiss_faddr", 32'(last_fetch_addr), 32'h11);
    check("wmiss_nwb", 32'(n_wb), 32'd1);
    req_op(1'b1, 1'b0, 8'h45, 8'h00, st, rd);
    check("wmiss_rd_stalls", 32'(st), 32'd0);
    check("wmiss_rd_data", 32'(rd), 32'h5A);
    req_op(1'b1, 1'b0, 8'h65, 8'h00, st, rd);
    check("evict1_stalls", 32'(st), 32'd12);
    check("evict1_wbaddr", 32'(last_wb_addr), 32'h11);
    check("evict1_wbdata", last_wb_data, 32'hDDCC_5AAA);
    check("evict1_data", 32'(rd), 32'h0D);
    check("evict1_nfetch", 32'(n_fetch), 32'd4);

    // Reset in the middle of a fetch
    @(negedge CLK);
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h0A;
    repeat (3) @(negedge CLK);
    #1;
    check("rstmid_fetching", 32'(MEM_READ), 32'd1);
    RESET = 1'b1; READ = 1'b0;
    @(negedge CLK);
    #1;
    check("rstmid_mem_read", 32'(MEM_READ), 32'd0);
    check("rstmid_mem_write", 32'(MEM_WRITE), 32'd0);
    check("rstmid_busywait", 32'(BUSYWAIT), 32'd0);
    $display("reset asserted during fetch of addr 0a");
    RESET = 1'b0;
    req_op(1'b1, 1'b0, 8'h0A, 8'h00, st, rd);
    check("rstmid_remiss_stalls", 32'(st), 32'd7);
    check("rstmid_remiss_data", 32'(rd), 32'hDE);
    check("rstmid_faddr", 32'(last_fetch_addr), 32'h02);
    check("rstmid_nfetch", 32'(n_fetch), 32'd5);

    // READ and WRITE together on a hit: write wins
    req_op(1'b1, 1'b1, 8'h0A, 8'h77, st, rd);
    check("rw_stalls", 32'(st), 32'd0);
    @(negedge CLK);
    #1;
    check("rw_readdata", 32'(READDATA), 32'h77);
    req_op(1'b1, 1'b0, 8'h2A, 8'h00, st, rd);
    check("rw_evict_stalls", 32'(st), 32'd12);
    check("rw_evict_wbaddr", 32'(last_wb_addr), 32'h02);
    check("rw_evict_wbdata", last_wb_data, 32'hC077_0002);
    check("rw_evict_data", 32'(rd), 32'hDE);
    check("rw_evict_nwb", 32'(n_wb), 32'd3);

    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
    @(negedge CLK);
    #1;
    check("idle_busywait", 32'(BUSYWAIT), 32'd0);
    check("never_both", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
